// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control sequencer.
// Contents:
//   OPW, ALUOPW, STATEW - opcode, ALUOp and state-register widths
//   state_t             - the 13 sequencer states
//   OP_*                - opcode values (instr[15:12])
//   ALUOP_*, SRCB_*, PCSRC_* - datapath select encodings
//   ctrl_t              - full control word driven to the datapath
//   op_defined()        - true for opcodes the core implements
package multicycle_ctrl_pkg;

  localparam int OPW    = 4;
  localparam int ALUOPW = 2;
  localparam int STATEW = 4;

  typedef enum logic [STATEW-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_I   = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_R    = 4'h0;
  localparam logic [OPW-1:0] OP_ADDI = 4'h1;
  localparam logic [OPW-1:0] OP_ANDI = 4'h2;
  localparam logic [OPW-1:0] OP_ORI  = 4'h3;
  localparam logic [OPW-1:0] OP_LW   = 4'h4;
  localparam logic [OPW-1:0] OP_SW   = 4'h5;
  localparam logic [OPW-1:0] OP_BEQ  = 4'h6;
  localparam logic [OPW-1:0] OP_BNE  = 4'h7;
  localparam logic [OPW-1:0] OP_J    = 4'h8;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  localparam logic [ALUOPW-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOPW-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOPW-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOPW-1:0] ALUOP_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_SEXT = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic              reg_dst;
    logic              reg_write;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic [ALUOPW-1:0] alu_op;
    logic              iord;
    logic              mem_req;
    logic              mem_write;
    logic              memto_reg;
    logic              ir_write;
    logic              pc_write;
    logic              pc_write_cond;
    logic              branch_ne;
    logic [1:0]        pc_src;
    logic              halted;
    logic              illegal_op;
  } ctrl_t;

  function automatic logic op_defined(input logic [OPW-1:0] op);
    return (op <= OP_J) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/datapath bus of the multi-cycle sequencer.
//   opcode, zero, mem_ready : from IR, ALU and memory port into the sequencer
//   RegDst .. illegal_op    : datapath selects, strobes and status from it
// master = sequencer side, slave = datapath/memory side.
interface multicycle_control_fsm_if;
  import multicycle_ctrl_pkg::*;

  logic [OPW-1:0]    opcode;
  logic              zero;
  logic              mem_ready;
  logic              RegDst;
  logic              RegWrite;
  logic              ALUSrcA;
  logic [1:0]        ALUSrcB;
  logic [ALUOPW-1:0] ALUOp;
  logic              IorD;
  logic              mem_req;
  logic              MemWrite;
  logic              MemtoReg;
  logic              IRWrite;
  logic              PCWrite;
  logic              PCWriteCond;
  logic              BranchNe;
  logic [1:0]        PCSrc;
  logic              halted;
  logic              illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, IorD, mem_req,
           MemWrite, MemtoReg, IRWrite, PCWrite, PCWriteCond, BranchNe,
           PCSrc, halted, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, IorD, mem_req,
           MemWrite, MemtoReg, IRWrite, PCWrite, PCWriteCond, BranchNe,
           PCSrc, halted, illegal_op
  );
endinterface

// File: rtl/multicycle_control_fsm_decode.sv
// mc_ctrl_decode: combinational control-word decoder.
//   state     in  current sequencer state
//   opcode    in  IR opcode field
//   mem_ready in  memory completed the current access
//   ctrl      out full control word (every field 0 unless set for the state)
module mc_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALUOP_ADD;
        // IR load and PC+1 only commit once the instruction word arrives
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.pc_src    = PCSRC_ALU;
      end
      DECODE: begin
        ctrl.alu_src_b  = SRCB_BOFF;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.illegal_op = !op_defined(opcode);
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = (opcode == OP_ADDI) ? ALUOP_ADD : ALUOP_LOGIC;
      end
      WB_I: begin
        ctrl.reg_write = 1'b1;
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.branch_ne     = (opcode == OP_BNE);
      end
      JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      HALT: begin
        ctrl.halted = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle instruction sequencer for the 8-register
// core. Holds the state register and next-state logic; the control word is
// decoded from state by mc_ctrl_decode.
//   clk   in  rising-edge clock
//   reset in  synchronous, active-high; returns to FETCH
//   bus   master modport of multicycle_control_fsm_if (opcode/zero/mem_ready
//         in, all datapath selects, strobes, halted, illegal_op out)
module multicycle_control_fsm
  import multicycle_ctrl_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  multicycle_control_fsm_if.master bus
);

  state_t state;
  ctrl_t  ctrl_dec;
  ctrl_t  ctrl;

  mc_ctrl_decode u_decode (
    .state     (state),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl_dec)
  );

  // While reset is held every strobe is forced low, so an access that was in
  // flight when reset arrived can never complete its write.
  assign ctrl = reset ? '0 : ctrl_dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.opcode)
            OP_R:                     state <= EXEC_R;
            OP_ADDI, OP_ANDI, OP_ORI: state <= EXEC_I;
            OP_LW, OP_SW:             state <= MEM_ADDR;
            OP_BEQ, OP_BNE:           state <= BRANCH;
            OP_J:                     state <= JUMP;
            OP_HALT:                  state <= HALT;
            default:                  state <= FETCH;  // undefined: NOP
          endcase
        end
        EXEC_R:   state <= WB_R;
        EXEC_I:   state <= WB_I;
        MEM_ADDR: state <= (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD:   if (bus.mem_ready) state <= MEM_WB;
        MEM_WR:   if (bus.mem_ready) state <= FETCH;
        HALT:     state <= HALT;
        default:  state <= FETCH;  // WB_R, WB_I, MEM_WB, BRANCH, JUMP
      endcase
    end
  end

  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.IorD        = ctrl.iord;
  assign bus.mem_req     = ctrl.mem_req;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.MemtoReg    = ctrl.memto_reg;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchNe    = ctrl.branch_ne;
  assign bus.PCSrc       = ctrl.pc_src;
  assign bus.halted      = ctrl.halted;
  assign bus.illegal_op  = ctrl.illegal_op;

endmodule
